div_tick_scheduler: RTL and testbench
=====================================

Name: div_tick_scheduler

Overview:
Shares one programmable tick divider between up to four requesters. Each requester asks for a burst of divided ticks with its own divide value and burst length. A round-robin arbiter grants the divider to one requester at a time. The block sequences load, run and release, and emits a tagged tick stream plus a completion pulse. It sits between the timing-consumer blocks and the system clock domain, and replaces per-consumer free-running dividers.

Parameters:
NREQ, 4, number of requesters; legal values 2..4; the ID fields are always 2 bits wide.
CW, 4, divider counter width.
LW, 4, burst-length field width.
CLK_DIV_VAL, 11, reload value used when a requester supplies a divide value of 0.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rstn  input  1  reset; asynchronous, active-high (asserted = 1).
enable  input  1  global count enable; when low, the counter and remaining count freeze.
req  input  NREQ  per-requester request level; held high until done or abandon.
div_val  input  NREQ*CW  divide value, requester i in bits [i*CW +: CW].
burst_len  input  NREQ*LW  tick count, requester i in bits [i*LW +: LW].
grant  output  NREQ  one-hot grant; all zero when idle.
busy  output  1  high while in RUN.
tick  output  1  one-cycle tick pulse.
tick_id  output  2  index of the owner of the tick.
done  output  1  one-cycle pulse when a burst completes normally.
abort  output  1  one-cycle pulse when the owner dropped req mid-burst.
done_id  output  2  index of the requester that completed or aborted; valid with done or abort.

Behaviour:
- All outputs are registered.
- Reset (rstn=1, asynchronous) forces: state=IDLE, grant=0, busy=0, tick=0, tick_id=0, done=0, abort=0, done_id=0, counter=0, remaining=0, last_grant=NREQ-1.
- The FSM has three states: IDLE, RUN, FIN.
- IDLE:
  - If any req bit is high, select the first requester at or after index last_grant+1 (mod NREQ).
  - In that same cycle: set the grant bit; latch div = (div_val_i==0 ? CLK_DIV_VAL : div_val_i); load counter<=div; latch remaining = (burst_len_i==0 ? 2^LW : burst_len_i); go to RUN.
  - enable does not gate arbitration.
- RUN, busy=1:
  - Each cycle, first check req[owner]. If it is low: assert abort=1 and done_id=owner on the next cycle, clear grant, set last_grant=owner, return to IDLE. No tick is issued that cycle.
  - Otherwise, with enable=1:
    - If counter==0: tick=1, tick_id=owner, counter<=div, remaining<=remaining-1. If remaining==1, go to FIN.
    - Else counter<=counter-1.
  - With enable=0, hold all state; tick=0.
  - Tick period is div+1 enabled cycles. The first tick comes on the (div+1)th enabled RUN cycle after grant.
- FIN, exactly one cycle:
  - done=1, done_id=owner.
  - grant clears at the end of the cycle; last_grant=owner; go to IDLE.
  - Requests are not arbitrated in FIN. Minimum gap between two bursts is therefore one IDLE cycle.
- Arithmetic:
  - counter is CW bits, unsigned, never decrements below 0.
  - remaining is LW+1 bits so it can hold 2^LW.
- div_val and burst_len are sampled only at grant; changes mid-burst are ignored.
- tick, done and abort are mutually exclusive in any cycle. Only one grant bit is ever high.
- A request arriving while another burst runs waits; it is not lost while req stays high.
- Reset mid-burst aborts immediately with no done or abort pulse.

Test Plan:
1. Single requester 0, div_val=0, burst_len=3, enable=1 → ticks 12 cycles apart starting 12 cycles after grant; done on the cycle after the 3rd tick; done_id=0; grant returns to 0.
2. req=4'b1111 held, each burst_len=1, div_val=2 → grant order 0,1,2,3,0; each tick 3 cycles after its grant.
3. Requester 2, div_val=4, burst_len=2, enable toggled low for 5 cycles between ticks → tick spacing grows by exactly 5 cycles; still 2 ticks then done.
4. Requester 1, burst_len=5, req dropped after the 2nd tick → abort=1 with done_id=1 one cycle later, no further ticks, requester 2 (waiting) granted next.
5. Requester 3, burst_len=0, div_val=1 → 16 ticks, 2 cycles apart, then done.
6. rstn pulsed high mid-RUN → all outputs 0 immediately (asynchronously); after release, last_grant=NREQ-1 so requester 0 wins the next arbitration.

Source files
------------

// File: rtl/div_tick_scheduler.sv
// div_tick_scheduler
//   Shares one programmable tick divider between NREQ requesters. A round-robin
//   arbiter hands the divider to one requester at a time. The owner receives a
//   burst of divided ticks, then a completion pulse. If the owner drops its
//   request mid-burst, an abort pulse is issued instead.
//
// Ports
//   clk        system clock, rising edge
//   rstn       asynchronous reset, active high (asserted = 1)
//   enable     global count enable; low freezes counter and remaining count
//   req        per-requester request level
//   div_val    divide values, requester i in [i*CW +: CW]; 0 selects CLK_DIV_VAL
//   burst_len  tick counts, requester i in [i*LW +: LW]; 0 selects 2^LW
//   grant      one-hot grant, zero when idle
//   busy       high while a burst is running
//   tick       one-cycle tick pulse, tagged by tick_id
//   done       one-cycle pulse on normal burst completion
//   abort      one-cycle pulse when the owner dropped req mid-burst
//   done_id    requester that completed or aborted
module div_tick_scheduler #(
    parameter int NREQ        = 4,
    parameter int CW          = 4,
    parameter int LW          = 4,
    parameter int CLK_DIV_VAL = 11
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               enable,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*CW-1:0] div_val,
    input  logic [NREQ*LW-1:0] burst_len,
    output logic [NREQ-1:0]    grant,
    output logic               busy,
    output logic               tick,
    output logic [1:0]         tick_id,
    output logic               done,
    output logic               abort,
    output logic [1:0]         done_id
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t        state;
    logic [1:0]    owner;
    logic [1:0]    last_grant;
    logic [CW-1:0] div;
    logic [CW-1:0] counter;
    logic [LW:0]   remaining;

    logic          sel_valid;
    logic [1:0]    sel_idx;
    logic [CW-1:0] div_sel;
    logic [LW-1:0] burst_sel;
    logic [LW:0]   rem_load;
    logic          owner_req;

    // Round-robin pick: scan from the farthest candidate back toward
    // last_grant+1 so the nearest requesting index is the last one written.
    always_comb begin
        int unsigned cand;
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int unsigned k = NREQ; k >= 1; k--) begin
            cand = (32'(last_grant) + k) % NREQ;
            if (|(req & (NREQ'(1) << cand))) begin
                sel_valid = 1'b1;
                sel_idx   = 2'(cand);
            end
        end
    end

    // Fields of the selected requester, with the zero-value substitutions.
    always_comb begin
        div_sel   = CW'(div_val >> (32'(sel_idx) * CW));
        burst_sel = LW'(burst_len >> (32'(sel_idx) * LW));
        if (div_sel == '0) begin
            div_sel = CW'(CLK_DIV_VAL);
        end
        if (burst_sel == '0) begin
            rem_load = {1'b1, {LW{1'b0}}};
        end else begin
            rem_load = {1'b0, burst_sel};
        end
    end

    assign owner_req = |(req & (NREQ'(1) << owner));

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state      <= IDLE;
            grant      <= '0;
            busy       <= 1'b0;
            tick       <= 1'b0;
            tick_id    <= '0;
            done       <= 1'b0;
            abort      <= 1'b0;
            done_id    <= '0;
            counter    <= '0;
            remaining  <= '0;
            div        <= '0;
            owner      <= '0;
            last_grant <= 2'(NREQ - 1);
        end else begin
            tick  <= 1'b0;
            done  <= 1'b0;
            abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        grant     <= NREQ'(1) << sel_idx;
                        owner     <= sel_idx;
                        div       <= div_sel;
                        counter   <= div_sel;
                        remaining <= rem_load;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    // A dropped request wins over any tick due this cycle.
                    if (!owner_req) begin
                        abort      <= 1'b1;
                        done_id    <= owner;
                        grant      <= '0;
                        last_grant <= owner;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else if (enable) begin
                        if (counter == '0) begin
                            tick      <= 1'b1;
                            tick_id   <= owner;
                            counter   <= div;
                            remaining <= remaining - (LW+1)'(1);
                            if (remaining == (LW+1)'(1)) begin
                                busy  <= 1'b0;
                                state <= FIN;
                            end
                        end else begin
                            counter <= counter - CW'(1);
                        end
                    end
                end
                FIN: begin
                    done       <= 1'b1;
                    done_id    <= owner;
                    grant      <= '0;
                    last_grant <= owner;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_tick_scheduler.sv
module tb_div_tick_scheduler;

    localparam int NREQ = 4;
    localparam int CW   = 4;
    localparam int LW   = 4;
    localparam int CDV  = 11;

    logic               clk = 1'b0;
    logic               rstn = 1'b1;
    logic               enable = 1'b1;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ*CW-1:0] div_val = '0;
    logic [NREQ*LW-1:0] burst_len = '0;
    logic [NREQ-1:0]    grant;
    logic               busy, tick, done, abort;
    logic [1:0]         tick_id, done_id;

    div_tick_scheduler #(.NREQ(NREQ), .CW(CW), .LW(LW), .CLK_DIV_VAL(CDV)) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .req(req),
        .div_val(div_val), .burst_len(burst_len), .grant(grant), .busy(busy),
        .tick(tick), .tick_id(tick_id), .done(done), .abort(abort), .done_id(done_id)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic chk_on = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: counts enabled cycles since the last tick (or grant)
    // and fires when div+1 have elapsed; tracks ticks left in the burst.
    int   m_state;   // 0 idle, 1 running, 2 finishing
    int   m_rr, m_owner, m_div, m_left, m_elapsed;
    logic [NREQ-1:0] e_grant;
    logic e_busy, e_tick, e_done, e_abort;
    int   e_tid, e_did;

    always @(posedge clk or posedge rstn) begin
        if (rstn) begin
            m_state = 0; m_rr = NREQ - 1; m_owner = 0; m_div = 0; m_left = 0; m_elapsed = 0;
            e_grant = '0; e_busy = 0; e_tick = 0; e_done = 0; e_abort = 0; e_tid = 0; e_did = 0;
        end else begin
            e_tick = 0; e_done = 0; e_abort = 0;
            case (m_state)
                0: begin
                    int pick;
                    pick = -1;
                    for (int k = 1; k <= NREQ; k++) begin
                        int c;
                        c = (m_rr + k) % NREQ;
                        if (pick < 0 && ((req >> c) & 1) != 0) pick = c;
                    end
                    if (pick >= 0) begin
                        int dv, bl;
                        dv = int'((div_val >> (pick * CW)) & 16'hF);
                        bl = int'((burst_len >> (pick * LW)) & 16'hF);
                        m_owner = pick;
                        m_div = (dv == 0) ? CDV : dv;
                        m_left = (bl == 0) ? 16 : bl;
                        m_elapsed = 0;
                        e_grant = NREQ'(1) << pick;
                        e_busy = 1;
                        m_state = 1;
                    end
                end
                1: begin
                    if (((req >> m_owner) & 1) == 0) begin
                        e_abort = 1; e_did = m_owner; e_grant = '0; e_busy = 0;
                        m_rr = m_owner; m_state = 0;
                    end else if (enable) begin
                        m_elapsed++;
                        if (m_elapsed == m_div + 1) begin
                            e_tick = 1; e_tid = m_owner; m_elapsed = 0; m_left--;
                            if (m_left == 0) begin
                                m_state = 2; e_busy = 0;
                            end
                        end
                    end
                end
                default: begin
                    e_done = 1; e_did = m_owner; e_grant = '0;
                    m_rr = m_owner; m_state = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("grant", int'(grant), int'(e_grant));
            check("busy", int'(busy), int'(e_busy));
            check("tick", int'(tick), int'(e_tick));
            check("done", int'(done), int'(e_done));
            check("abort", int'(abort), int'(e_abort));
            if (e_tick) check("tick_id", int'(tick_id), e_tid);
            if (e_done || e_abort) check("done_id", int'(done_id), e_did);
        end
    end

    // Event log for the directed, hand-computed checks.
    int g_cyc[$], g_val[$], t_cyc[$], t_id[$], d_cyc[$], d_id[$], a_cyc[$], a_id[$];
    logic [NREQ-1:0] prev_grant = '0;

    always @(negedge clk) begin
        if (grant != '0 && prev_grant == '0) begin
            g_cyc.push_back(cyc); g_val.push_back(int'(grant));
        end
        if (tick)  begin t_cyc.push_back(cyc); t_id.push_back(int'(tick_id)); end
        if (done)  begin d_cyc.push_back(cyc); d_id.push_back(int'(done_id)); end
        if (abort) begin a_cyc.push_back(cyc); a_id.push_back(int'(done_id)); end
        prev_grant = grant;
    end

    function automatic int qget(input int q[$], input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic clear_log();
        g_cyc.delete(); g_val.delete(); t_cyc.delete(); t_id.delete();
        d_cyc.delete(); d_id.delete(); a_cyc.delete(); a_id.delete();
    endtask

    task automatic set_lane(input int l, input int d, input int b);
        div_val[l*CW +: CW]   = CW'(d);
        burst_len[l*LW +: LW] = LW'(b);
    endtask

    // Waits (bounded) until done+abort events reach want; returns #1 after a negedge.
    task automatic wait_ends(input string name, input int want, input int budget);
        int n;
        n = 0;
        while ((d_cyc.size() + a_cyc.size()) < want && n < budget) begin
            @(negedge clk); #1; n++;
        end
        if ((d_cyc.size() + a_cyc.size()) < want)
            check({name, "_wait_end"}, d_cyc.size() + a_cyc.size(), want);
    endtask

    task automatic wait_ticks(input string name, input int want, input int budget);
        int n;
        n = 0;
        while (t_cyc.size() < want && n < budget) begin
            @(negedge clk); #1; n++;
        end
        if (t_cyc.size() < want) check({name, "_wait_tick"}, t_cyc.size(), want);
    endtask

    task automatic pulse_reset();
        @(negedge clk); #1 rstn = 1'b1;
        @(negedge clk); #1 rstn = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        repeat (3) @(negedge clk);
        check("rst_grant", int'(grant), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_done", int'(done), 0);
        check("rst_abort", int'(abort), 0);
        check("rst_tick_id", int'(tick_id), 0);
        check("rst_done_id", int'(done_id), 0);
        #1 rstn = 1'b0;
        chk_on = 1'b1;
        @(negedge clk); #1;

        // 1: requester 0, default divide (11), burst 3.
        clear_log();
        set_lane(0, 0, 3); req = 4'b0001;
        wait_ends("t1", 1, 100);
        req = '0;
        repeat (2) @(negedge clk); #1;
        check("t1_ntick", t_cyc.size(), 3);
        check("t1_first", qget(t_cyc, 0) - qget(g_cyc, 0), 12);
        check("t1_gap1", qget(t_cyc, 1) - qget(t_cyc, 0), 12);
        check("t1_gap2", qget(t_cyc, 2) - qget(t_cyc, 1), 12);
        check("t1_done_lat", qget(d_cyc, 0) - qget(t_cyc, 2), 1);
        check("t1_done_id", qget(d_id, 0), 0);
        check("t1_grant_idle", int'(grant), 0);

        // 2: all four request, burst 1, divide 2; round robin from reset.
        pulse_reset();
        clear_log();
        for (int l = 0; l < NREQ; l++) set_lane(l, 2, 1);
        req = 4'b1111;
        wait_ends("t2", 5, 200);
        req = '0;
        repeat (2) @(negedge clk); #1;
        check("t2_g0", qget(g_val, 0), 1);
        check("t2_g1", qget(g_val, 1), 2);
        check("t2_g2", qget(g_val, 2), 4);
        check("t2_g3", qget(g_val, 3), 8);
        check("t2_g4", qget(g_val, 4), 1);
        for (int i = 0; i < 5; i++) check("t2_tick_lat", qget(t_cyc, i) - qget(g_cyc, i), 3);

        // 3: requester 2, divide 4, burst 2, enable low for 5 cycles after tick 1.
        clear_log();
        set_lane(2, 4, 2); req = 4'b0100;
        wait_ticks("t3", 1, 100);
        enable = 1'b0;
        repeat (5) @(negedge clk);
        #1 enable = 1'b1;
        wait_ends("t3", 1, 100);
        req = '0;
        repeat (2) @(negedge clk); #1;
        check("t3_ntick", t_cyc.size(), 2);
        check("t3_first", qget(t_cyc, 0) - qget(g_cyc, 0), 5);
        check("t3_gap", qget(t_cyc, 1) - qget(t_cyc, 0), 10);
        check("t3_done_lat", qget(d_cyc, 0) - qget(t_cyc, 1), 1);
        check("t3_done_id", qget(d_id, 0), 2);

        // 4: requester 1 burst 5 abandoned after tick 2; requester 2 waiting.
        clear_log();
        set_lane(1, 2, 5); set_lane(2, 1, 1);
        req = 4'b0110;
        wait_ticks("t4", 2, 100);
        req = 4'b0100;
        wait_ends("t4", 2, 100);
        req = '0;
        repeat (2) @(negedge clk); #1;
        cnt = 0;
        foreach (t_id[i]) if (t_id[i] == 1) cnt++;
        check("t4_first_grant", qget(g_val, 0), 2);
        check("t4_owner_ticks", cnt, 2);
        check("t4_nabort", a_cyc.size(), 1);
        check("t4_abort_lat", qget(a_cyc, 0) - qget(t_cyc, 1), 1);
        check("t4_abort_id", qget(a_id, 0), 1);
        check("t4_next_grant", qget(g_val, 1), 4);
        check("t4_regrant_lat", qget(g_cyc, 1) - qget(a_cyc, 0), 1);

        // 5: requester 3, burst 0 (=16), divide 1.
        clear_log();
        set_lane(3, 1, 0); req = 4'b1000;
        wait_ends("t5", 1, 200);
        req = '0;
        repeat (2) @(negedge clk); #1;
        check("t5_ntick", t_cyc.size(), 16);
        check("t5_first", qget(t_cyc, 0) - qget(g_cyc, 0), 2);
        for (int i = 1; i < 16; i++) check("t5_gap", qget(t_cyc, i) - qget(t_cyc, i - 1), 2);
        check("t5_done_lat", qget(d_cyc, 0) - qget(t_cyc, 15), 1);
        check("t5_done_id", qget(d_id, 0), 3);

        // 6: move last_grant to 1, start requester 2, reset mid-burst.
        clear_log();
        set_lane(1, 0, 1); req = 4'b0010;
        wait_ends("t6a", 1, 100);
        req = '0;
        @(negedge clk); #1;
        clear_log();
        set_lane(2, 5, 4); set_lane(0, 0, 1);
        req = 4'b0100;
        @(negedge clk); #1;
        check("t6_granted", int'(grant), 4);
        repeat (3) @(posedge clk);
        #2 rstn = 1'b1;
        #1;
        check("t6_async_grant", int'(grant), 0);
        check("t6_async_busy", int'(busy), 0);
        check("t6_async_tick", int'(tick), 0);
        check("t6_async_tick_id", int'(tick_id), 0);
        check("t6_async_done", int'(done), 0);
        check("t6_async_abort", int'(abort), 0);
        check("t6_async_done_id", int'(done_id), 0);
        req = 4'b0101;
        @(negedge clk); #1 rstn = 1'b0;
        @(negedge clk); #1;
        check("t6_rr_after_reset", int'(grant), 1);
        req = 4'b0001;
        wait_ends("t6b", 1, 100);
        req = '0;
        repeat (2) @(negedge clk); #1;
        check("t6_nabort", a_cyc.size(), 0);
        check("t6_ndone", d_cyc.size(), 1);
        check("t6_done_id", qget(d_id, 0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
